// File: rtl/shift_register_tap.sv
// shift_register_tap: multi-channel tapped shift register with per-channel valid and fill tracking.
// Build option SHIFT_REG_TAP_DATA_RESET_EN adds an asynchronous clear to the data stages.
module shift_register_tap #(
    parameter int DATAW     = 8,
    parameter int CHANNELS  = 2,
    parameter int MAX_DEPTH = 8,
    parameter int DEPTHW    = $clog2(MAX_DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic                      flush,
    input  logic [DEPTHW-1:0]         tap_sel,
    input  logic [CHANNELS*DATAW-1:0] data_in,
    input  logic [CHANNELS-1:0]       valid_in,
    output logic [CHANNELS*DATAW-1:0] data_out,
    output logic [CHANNELS-1:0]       valid_out,
    output logic                      primed
);

    localparam int CNTW = $clog2(MAX_DEPTH + 1);
    localparam logic [CNTW-1:0] FILL_MAX = CNTW'(MAX_DEPTH);

    logic [CHANNELS*DATAW-1:0] stage_q [MAX_DEPTH];
    logic [CHANNELS-1:0]       vld_q   [MAX_DEPTH];
    logic [CNTW-1:0]           fill_q;
    logic [CNTW-1:0]           fill_d;
    logic [DEPTHW-1:0]         tap_idx;
    logic                      shift;

    // Flush wins over enable, so a flushed cycle never advances the data stages.
    assign shift = enable & ~flush;

`ifdef SHIFT_REG_TAP_DATA_RESET_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else if (shift) begin
            stage_q[0] <= data_in;
            for (int i = 1; i < MAX_DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (shift) begin
            stage_q[0] <= data_in;
            for (int i = 1; i < MAX_DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_DEPTH; i++) begin
                vld_q[i] <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < MAX_DEPTH; i++) begin
                vld_q[i] <= '0;
            end
        end else if (enable) begin
            vld_q[0] <= valid_in;
            for (int i = 1; i < MAX_DEPTH; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
        end
    end

    always_comb begin
        fill_d = fill_q;
        if (flush) begin
            fill_d = '0;
        end else if (enable && (fill_q != FILL_MAX)) begin
            fill_d = fill_q + CNTW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_q <= '0;
        end else begin
            fill_q <= fill_d;
        end
    end

    // Out-of-range taps (only possible for non-power-of-2 depths) clamp to the last stage.
    always_comb begin
        tap_idx = tap_sel;
        if (32'(tap_sel) >= MAX_DEPTH) begin
            tap_idx = DEPTHW'(MAX_DEPTH - 1);
        end
    end

    assign primed    = 32'(fill_q) > 32'(tap_idx);
    assign data_out  = stage_q[tap_idx];
    assign valid_out = vld_q[tap_idx] & {CHANNELS{primed}};

endmodule
